// File: rtl/gserialsub.sv
// Bit-serial A - B - BIN, LSB first, one full-subtractor cell plus a borrow FF; latency WIDTH cycles.
// Valid/ready on both sides: in_ready only in IDLE, and the result holds in HOLD until out_ready.
module gserialsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_br, r_amsb, r_bmsb, r_bout, r_ovf;
    logic             w_d, w_br_nxt, w_last;

    // Full-subtractor cell on the current LSBs
    assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_last   = (r_cnt == LAST);

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_last) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_br   <= 1'b0;
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_br   <= bin;
                        r_amsb <= a[WIDTH-1];
                        r_bmsb <= b[WIDTH-1];
                        r_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_res <= {w_d, r_res[WIDTH-1:1]};
                    r_br  <= w_br_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    // The bit produced on the last cycle is the result MSB
                    if (w_last) begin
                        r_bout <= w_br_nxt;
                        r_ovf  <= (r_amsb != r_bmsb) && (w_d != r_amsb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = r_res;
    assign bout = r_bout;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_gserialsub.sv
// Bench for gserialsub: directed corner cases, reset abort, stall behaviour and random operands vs. an arithmetic model.
module tb_gserialsub;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, bin, out_valid, out_ready, bout, ovf;
    logic [W-1:0] a, b, diff;

    int n_assert = 0;
    int n_fail   = 0;

    gserialsub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete operation; the expected result comes from integer arithmetic
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                          input int stall);
        logic [W:0]   full;
        logic [W-1:0] held;
        int           sd, lat;
        logic         eovf;
        full = {1'b0, ta} - {1'b0, tb_v} - {{W{1'b0}}, tbin};
        sd   = int'($signed(ta)) - int'($signed(tb_v)) - int'(tbin);
        eovf = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);

        check("in_ready_before", in_ready, 1);
        a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("in_ready_busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, W);
        check("diff", diff, full[W-1:0]);
        check("bout", bout, full[W]);
        check("ovf", ovf, eovf);

        held = diff;
        for (int i = 0; i < stall; i++) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            in_valid = ~in_valid;
            @(posedge clk); #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_diff", diff, held);
        end

        // Handshake with a stale in_valid present: it must not be taken
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        @(posedge clk); #1;
        check("no_stale_capture", in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h35, 8'h12, 1'b0, 0);
        check("t1_diff", diff, 32'h23);
        run_op(8'h00, 8'h01, 1'b0, 1);
        run_op(8'h80, 8'h01, 1'b0, 0);
        run_op(8'h7F, 8'hFF, 1'b0, 0);
        run_op(8'h10, 8'h0F, 1'b1, 2);
        run_op(8'h05, 8'h05, 1'b1, 0);
        run_op(8'hA7, 8'h3C, 1'b0, 5);

        // Abort mid-operation with an asynchronous reset
        a = 8'h55; b = 8'h0F; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_diff", diff, 0);
        #2;
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            check("abort_no_result", out_valid, 0);
        end
        run_op(8'h35, 8'h12, 1'b0, 0);

        for (int n = 0; n < 1000; n++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
